// File: rtl/aq_ifu_icache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// aq_ifu_icache_tag_ctrl
//
// Front-end controller for the 2-way I-cache tag SRAM (256 sets x 59 bits).
// The block shares one array port between three kinds of access:
//   - the invalidate-all sweep (highest priority),
//   - refill tag writes,
//   - fetch tag lookups (lowest priority).
// Each cycle carries at most one array operation. Lookup results are compared
// against the array read data one cycle after the read.
//
// Entry layout: [58]=fifo (next victim way), [57]=way1 valid, [56:29]=way1 tag,
//               [28]=way0 valid, [27:0]=way0 tag
//
// Ports
//   forever_cpuclk  in   clock
//   cpurst          in   synchronous reset, active high
//   inv_req         in   request an invalidate of every set
//   inv_busy        out  sweep in progress
//   inv_done        out  one-cycle pulse after the last set has been written
//   refill_vld      in   refill tag write request (idx/tag/way)
//   refill_ready    out  refill accepted this cycle
//   fetch_vld       in   lookup request (idx/tag)
//   fetch_ready     out  lookup accepted this cycle
//   icache_tag_*    out  array port: cen, wen {fifo,way1,way0}, idx, din
//   icache_tag_dout in   array read data, valid the cycle after a read
//   lkup_vld        out  lookup result valid
//   lkup_hit_way    out  {way1,way0} hit
//   lkup_miss       out  valid lookup with no way hit
//   lkup_victim     out  fifo bit of the looked-up set
// -----------------------------------------------------------------------------
module aq_ifu_icache_tag_ctrl #(
    parameter int TAG_W   = 28,
    parameter int INDEX_W = 8
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst,

    input  logic                   inv_req,
    output logic                   inv_busy,
    output logic                   inv_done,

    input  logic                   refill_vld,
    input  logic [INDEX_W-1:0]     refill_idx,
    input  logic [TAG_W-1:0]       refill_tag,
    input  logic                   refill_way,
    output logic                   refill_ready,

    input  logic                   fetch_vld,
    input  logic [INDEX_W-1:0]     fetch_idx,
    input  logic [TAG_W-1:0]       fetch_tag,
    output logic                   fetch_ready,

    output logic                   icache_tag_cen,
    output logic [2:0]             icache_tag_wen,
    output logic [INDEX_W:0]       icache_tag_idx,
    output logic [2*TAG_W+2:0]     icache_tag_din,
    input  logic [2*TAG_W+2:0]     icache_tag_dout,

    output logic                   lkup_vld,
    output logic [1:0]             lkup_hit_way,
    output logic                   lkup_miss,
    output logic                   lkup_victim
);

    localparam int WAY_W   = TAG_W + 1;       // valid + tag
    localparam int ENTRY_W = 2 * WAY_W + 1;   // two ways + fifo bit

    typedef enum logic {
        IDLE = 1'b0,
        INV  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [INDEX_W-1:0] inv_cnt;
    logic               inv_last;
    logic               inv_done_q;
    logic               lkup_pend;
    logic [TAG_W-1:0]   fetch_tag_q;
    logic               way0_hit;
    logic               way1_hit;

    assign inv_last = (state == INV) && (inv_cnt == {INDEX_W{1'b1}});

    // NOTE: every sequential register uses non-blocking assignment so all
    // flops update together from the values present before the edge.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state       <= IDLE;
            inv_cnt     <= '0;
            inv_done_q  <= 1'b0;
            lkup_pend   <= 1'b0;
            fetch_tag_q <= '0;
        end else begin
            state      <= state_nxt;
            inv_done_q <= inv_last;
            lkup_pend  <= fetch_ready;
            // Counter wraps from the last set back to 0 on its own, so the
            // next sweep always starts at set 0.
            if (state == INV) begin
                inv_cnt <= inv_cnt + 1'b1;
            end
            if (fetch_ready) begin
                fetch_tag_q <= fetch_tag;
            end
        end
    end

    // Array port arbitration and next state. Everything is gated while reset
    // is held so the port is quiet during the reset cycle itself.
    // NOTE: all outputs of this block get a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        icache_tag_cen = 1'b0;
        icache_tag_wen = 3'b000;
        icache_tag_idx = '0;
        icache_tag_din = '0;
        refill_ready   = 1'b0;
        fetch_ready    = 1'b0;

        if (!cpurst) begin
            case (state)
                INV: begin
                    icache_tag_cen = 1'b1;
                    icache_tag_wen = 3'b111;
                    icache_tag_idx = {1'b0, inv_cnt};
                    if (inv_last) begin
                        state_nxt = IDLE;
                    end
                end
                IDLE: begin
                    if (inv_req) begin
                        state_nxt = INV;
                    end
                    if (refill_vld) begin
                        refill_ready   = 1'b1;
                        icache_tag_cen = 1'b1;
                        icache_tag_wen = {1'b1, refill_way, ~refill_way};
                        icache_tag_idx = {1'b0, refill_idx};
                        // Both way fields carry the new tag; wen masks the
                        // way that is not being written. The fifo bit points
                        // at the other way as the next victim.
                        icache_tag_din = {~refill_way,
                                          1'b1, refill_tag,
                                          1'b1, refill_tag};
                    end else if (fetch_vld) begin
                        fetch_ready    = 1'b1;
                        icache_tag_cen = 1'b1;
                        icache_tag_idx = {1'b0, fetch_idx};
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Lookup compare on the read data returned one cycle after the read.
    assign way0_hit = icache_tag_dout[TAG_W] &&
                      (icache_tag_dout[TAG_W-1:0] == fetch_tag_q);
    assign way1_hit = icache_tag_dout[WAY_W+TAG_W] &&
                      (icache_tag_dout[WAY_W+TAG_W-1:WAY_W] == fetch_tag_q);

    assign lkup_vld     = lkup_pend & ~cpurst;
    assign lkup_hit_way = {2{lkup_vld}} & {way1_hit, way0_hit};
    assign lkup_miss    = lkup_vld & ~(|lkup_hit_way);
    assign lkup_victim  = lkup_vld & icache_tag_dout[ENTRY_W-1];

    assign inv_busy = (state == INV) & ~cpurst;
    assign inv_done = inv_done_q & ~cpurst;

endmodule

// File: tb/tb_aq_ifu_icache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aq_ifu_icache_tag_ctrl
//
// Directed bench for the I-cache tag controller. A behavioural tag array sits
// on the array port. A reference copy of the tag contents is kept from the
// stimulus. Expected lookup results are queued when a fetch is accepted and
// popped the following cycle.
// -----------------------------------------------------------------------------
module tb_aq_ifu_icache_tag_ctrl;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        inv_req;
    logic        inv_busy;
    logic        inv_done;
    logic        refill_vld;
    logic [7:0]  refill_idx;
    logic [27:0] refill_tag;
    logic        refill_way;
    logic        refill_ready;
    logic        fetch_vld;
    logic [7:0]  fetch_idx;
    logic [27:0] fetch_tag;
    logic        fetch_ready;
    logic        cen;
    logic [2:0]  wen;
    logic [8:0]  idx;
    logic [58:0] din;
    logic [58:0] dout;
    logic        lkup_vld;
    logic [1:0]  lkup_hit_way;
    logic        lkup_miss;
    logic        lkup_victim;

    always #5 clk = ~clk;

    aq_ifu_icache_tag_ctrl dut (
        .forever_cpuclk  (clk),
        .cpurst          (cpurst),
        .inv_req         (inv_req),
        .inv_busy        (inv_busy),
        .inv_done        (inv_done),
        .refill_vld      (refill_vld),
        .refill_idx      (refill_idx),
        .refill_tag      (refill_tag),
        .refill_way      (refill_way),
        .refill_ready    (refill_ready),
        .fetch_vld       (fetch_vld),
        .fetch_idx       (fetch_idx),
        .fetch_tag       (fetch_tag),
        .fetch_ready     (fetch_ready),
        .icache_tag_cen  (cen),
        .icache_tag_wen  (wen),
        .icache_tag_idx  (idx),
        .icache_tag_din  (din),
        .icache_tag_dout (dout),
        .lkup_vld        (lkup_vld),
        .lkup_hit_way    (lkup_hit_way),
        .lkup_miss       (lkup_miss),
        .lkup_victim     (lkup_victim)
    );

    // Behavioural tag array: bit-group write enables, registered read data.
    logic [58:0] mem [256];
    always @(posedge clk) begin
        if (cen) begin
            if (wen == 3'b000) begin
                dout <= mem[idx[7:0]];
            end else begin
                if (wen[0]) mem[idx[7:0]][28:0]  <= din[28:0];
                if (wen[1]) mem[idx[7:0]][57:29] <= din[57:29];
                if (wen[2]) mem[idx[7:0]][58]    <= din[58];
            end
        end
    end

    // Reference tag contents, updated from accepted stimulus.
    logic        ref_v0 [256];
    logic        ref_v1 [256];
    logic [27:0] ref_t0 [256];
    logic [27:0] ref_t1 [256];
    logic        ref_f  [256];

    typedef struct {
        logic [1:0] hit;
        logic       miss;
        logic       victim;
    } lk_t;

    typedef struct {
        logic        cen;
        logic [2:0]  wen;
        logic [8:0]  idx;
        logic [58:0] din;
        logic [58:0] mask;
        bit          do_idx;
    } port_t;

    lk_t exp_q[$];
    bit  exp_due = 1'b0;
    bit  tb_busy = 1'b0;
    bit  tb_done = 1'b0;
    int  tests   = 0;
    int  fails   = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic port_t p_idle();
        return '{cen: 1'b0, wen: 3'b000, idx: 9'd0, din: '0, mask: '0, do_idx: 1'b0};
    endfunction

    function automatic port_t p_rst();
        return '{cen: 1'b0, wen: 3'b000, idx: 9'd0, din: '0, mask: {59{1'b1}}, do_idx: 1'b1};
    endfunction

    function automatic port_t p_inv(input int k);
        return '{cen: 1'b1, wen: 3'b111, idx: 9'(k), din: '0, mask: {59{1'b1}}, do_idx: 1'b1};
    endfunction

    function automatic port_t p_fetch(input logic [7:0] i);
        return '{cen: 1'b1, wen: 3'b000, idx: {1'b0, i}, din: '0, mask: '0, do_idx: 1'b1};
    endfunction

    function automatic port_t p_refill(input logic [7:0] i, input logic [27:0] t, input logic w);
        port_t p;
        p.cen    = 1'b1;
        p.wen    = w ? 3'b110 : 3'b101;
        p.idx    = {1'b0, i};
        p.do_idx = 1'b1;
        p.din    = '0;
        p.mask   = '0;
        p.din[58]  = ~w;
        p.mask[58] = 1'b1;
        if (w) begin
            p.din[57:29]  = {1'b1, t};
            p.mask[57:29] = {29{1'b1}};
        end else begin
            p.din[28:0]  = {1'b1, t};
            p.mask[28:0] = {29{1'b1}};
        end
        return p;
    endfunction

    // One clock cycle: check at the falling edge, then advance to just after
    // the next rising edge where the caller changes inputs.
    task automatic cycle(input bit do_port, input port_t p);
        bit  exp_f;
        bit  exp_r;
        lk_t e;
        @(negedge clk);
        if (exp_due) begin
            chk("lkup_vld", lkup_vld, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("lkup_hit_way", lkup_hit_way, e.hit);
                chk("lkup_miss", lkup_miss, e.miss);
                chk("lkup_victim", lkup_victim, e.victim);
            end
        end else begin
            chk("lkup_vld_quiet", lkup_vld, 0);
        end
        exp_due = 1'b0;

        exp_f = !tb_busy && !cpurst && fetch_vld && !refill_vld;
        exp_r = !tb_busy && !cpurst && refill_vld;
        chk("fetch_ready", fetch_ready, exp_f);
        chk("refill_ready", refill_ready, exp_r);
        chk("inv_busy", inv_busy, tb_busy && !cpurst);
        chk("inv_done", inv_done, tb_done && !cpurst);
        tb_done = 1'b0;

        if (do_port) begin
            chk("tag_cen", cen, p.cen);
            chk("tag_wen", wen, p.wen);
            if (p.do_idx) chk("tag_idx", idx, p.idx);
            chk("tag_din", din & p.mask, p.din & p.mask);
        end

        if (exp_f) begin
            e.hit[0] = ref_v0[fetch_idx] && (ref_t0[fetch_idx] == fetch_tag);
            e.hit[1] = ref_v1[fetch_idx] && (ref_t1[fetch_idx] == fetch_tag);
            e.miss   = (e.hit == 2'b00);
            e.victim = ref_f[fetch_idx];
            exp_q.push_back(e);
            exp_due = 1'b1;
        end
        if (exp_r) begin
            if (refill_way) begin
                ref_v1[refill_idx] = 1'b1;
                ref_t1[refill_idx] = refill_tag;
            end else begin
                ref_v0[refill_idx] = 1'b1;
                ref_t0[refill_idx] = refill_tag;
            end
            ref_f[refill_idx] = ~refill_way;
        end
        @(posedge clk);
        #1;
    endtask

    // Pulse inv_req, then check n sweep writes. A full sweep clears the
    // reference contents and expects inv_done on the following cycle.
    task automatic sweep(input int n, input bit full);
        inv_req = 1'b1;
        cycle(1'b0, p_idle());
        inv_req = 1'b0;
        tb_busy = 1'b1;
        for (int k = 0; k < n; k++) begin
            cycle(1'b1, p_inv(k));
        end
        if (full) begin
            tb_busy = 1'b0;
            tb_done = 1'b1;
            for (int s = 0; s < 256; s++) begin
                ref_v0[s] = 1'b0;
                ref_v1[s] = 1'b0;
                ref_t0[s] = '0;
                ref_t1[s] = '0;
                ref_f[s]  = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 256; s++) begin
            ref_v0[s] = 1'b0;
            ref_v1[s] = 1'b0;
            ref_t0[s] = '0;
            ref_t1[s] = '0;
            ref_f[s]  = 1'b0;
        end
        cpurst     = 1'b1;
        inv_req    = 1'b0;
        refill_vld = 1'b0;
        refill_idx = '0;
        refill_tag = '0;
        refill_way = 1'b0;
        fetch_vld  = 1'b0;
        fetch_idx  = '0;
        fetch_tag  = '0;
        @(posedge clk);
        #1;

        // Reset state
        cycle(1'b1, p_rst());
        cycle(1'b1, p_rst());
        cpurst = 1'b0;
        cycle(1'b1, p_idle());

        // Full invalidate sweep, inv_done pulses once
        sweep(256, 1'b1);
        cycle(1'b1, p_idle());
        cycle(1'b1, p_idle());

        // Refill way1 of set 5, then hit and miss lookups back to back
        refill_vld = 1'b1;
        refill_idx = 8'd5;
        refill_tag = 28'hABCDEF1;
        refill_way = 1'b1;
        cycle(1'b1, p_refill(8'd5, 28'hABCDEF1, 1'b1));
        refill_vld = 1'b0;
        fetch_vld  = 1'b1;
        fetch_idx  = 8'd5;
        fetch_tag  = 28'hABCDEF1;
        cycle(1'b1, p_fetch(8'd5));
        fetch_tag  = 28'h1234567;
        cycle(1'b1, p_fetch(8'd5));
        fetch_vld  = 1'b0;
        cycle(1'b1, p_idle());

        // Refill and fetch in the same cycle: refill wins, no lookup result
        refill_vld = 1'b1;
        refill_idx = 8'd7;
        refill_tag = 28'h0000055;
        refill_way = 1'b0;
        fetch_vld  = 1'b1;
        fetch_idx  = 8'd5;
        fetch_tag  = 28'hABCDEF1;
        cycle(1'b1, p_refill(8'd7, 28'h0000055, 1'b0));
        refill_vld = 1'b0;
        fetch_idx  = 8'd7;
        fetch_tag  = 28'h0000055;
        cycle(1'b1, p_fetch(8'd7));
        fetch_vld  = 1'b0;
        refill_vld = 1'b1;
        refill_way = 1'b1;
        cycle(1'b1, p_refill(8'd7, 28'h0000055, 1'b1));
        refill_vld = 1'b0;
        fetch_vld  = 1'b1;
        cycle(1'b1, p_fetch(8'd7));
        fetch_vld  = 1'b0;
        cycle(1'b1, p_idle());

        // Sweep arriving during a fetch stream blocks fetches throughout
        fetch_vld = 1'b1;
        fetch_idx = 8'd5;
        fetch_tag = 28'hABCDEF1;
        cycle(1'b1, p_fetch(8'd5));
        sweep(256, 1'b1);
        cycle(1'b1, p_fetch(8'd5));
        fetch_vld = 1'b0;
        cycle(1'b1, p_idle());

        // Reset in the middle of a sweep: abort, no inv_done, restart at 0
        sweep(100, 1'b0);
        cpurst = 1'b1;
        cycle(1'b1, p_rst());
        cpurst  = 1'b0;
        tb_busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, p_idle());
        end
        sweep(256, 1'b1);
        cycle(1'b1, p_idle());

        // Last set boundary: refill way0 of set 255 and look it up
        refill_vld = 1'b1;
        refill_idx = 8'd255;
        refill_tag = 28'hFFFFFFF;
        refill_way = 1'b0;
        cycle(1'b1, p_refill(8'd255, 28'hFFFFFFF, 1'b0));
        refill_vld = 1'b0;
        fetch_vld  = 1'b1;
        fetch_idx  = 8'd255;
        fetch_tag  = 28'hFFFFFFF;
        cycle(1'b1, p_fetch(8'd255));
        fetch_idx  = 8'd5;
        fetch_tag  = 28'hABCDEF1;
        cycle(1'b1, p_fetch(8'd5));
        fetch_vld  = 1'b0;
        cycle(1'b1, p_idle());
        cycle(1'b1, p_idle());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
